// File: rtl/acc32_signed_seq.sv
// Sequential signed accumulator. It takes a stream of two's-complement operands over a
// valid/ready handshake and folds them into a running sum. When the job ends it presents the
// sum, a sticky overflow flag and the last carry-out. Saturation on overflow is optional.
module acc32_signed_seq #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COUNT_W-1:0] len,
  input  logic               sat_en,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               overflow,
  output logic               cout_last,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  localparam logic [WIDTH-1:0]   MaxPos = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]   MaxNeg = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [COUNT_W-1:0] CntOne = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_e             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_acc, w_acc_nxt;
  logic [COUNT_W-1:0] r_rem, w_rem_nxt;
  logic               r_ovf, w_ovf_nxt;
  logic               r_cout, w_cout_nxt;
  logic               r_sat, w_sat_nxt;

  logic [WIDTH:0]     w_sum;
  logic               w_add_ovf;
  logic               w_beat;
  logic               w_start_ok;

  // Adder with Cin=0. The extra top bit is the unsigned carry-out.
  assign w_sum      = {1'b0, r_acc} + {1'b0, in_data};
  assign w_add_ovf  = (r_acc[WIDTH-1] == in_data[WIDTH-1]) && (w_sum[WIDTH-1] != r_acc[WIDTH-1]);
  assign w_beat     = (r_state == StAccum) && in_valid;
  assign w_start_ok = (r_state == StIdle) && start;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: begin
        if (start) begin
          w_state_nxt = (len == '0) ? StDone : StAccum;
        end
      end
      StAccum: begin
        if (in_valid && (r_rem == CntOne)) begin
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Datapath next values: clear on start, fold in each accepted beat, otherwise hold
  always_comb begin
    w_acc_nxt  = r_acc;
    w_rem_nxt  = r_rem;
    w_ovf_nxt  = r_ovf;
    w_cout_nxt = r_cout;
    w_sat_nxt  = r_sat;
    if (w_start_ok) begin
      w_acc_nxt  = '0;
      w_ovf_nxt  = 1'b0;
      w_cout_nxt = 1'b0;
      w_rem_nxt  = len;
      w_sat_nxt  = sat_en;
    end else if (w_beat) begin
      w_cout_nxt = w_sum[WIDTH];
      w_ovf_nxt  = r_ovf | w_add_ovf;
      w_rem_nxt  = r_rem - CntOne;
      if (w_add_ovf && r_sat) begin
        // Clamp toward the sign of the pre-add accumulator
        w_acc_nxt = r_acc[WIDTH-1] ? MaxNeg : MaxPos;
      end else begin
        w_acc_nxt = w_sum[WIDTH-1:0];
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_rem  <= '0;
      r_ovf  <= 1'b0;
      r_cout <= 1'b0;
      r_sat  <= 1'b0;
    end else begin
      r_acc  <= w_acc_nxt;
      r_rem  <= w_rem_nxt;
      r_ovf  <= w_ovf_nxt;
      r_cout <= w_cout_nxt;
      r_sat  <= w_sat_nxt;
    end
  end

  assign in_ready  = (r_state == StAccum);
  assign out_valid = (r_state == StDone);
  assign busy      = (r_state == StAccum) || (r_state == StDone);
  assign result    = r_acc;
  assign overflow  = r_ovf;
  assign cout_last = r_cout;

endmodule

// File: doc/acc32_signed_seq.md
Name: acc32_signed_seq

Overview:
Sequential signed accumulator directly downstream of the 32-bit signed ripple adder. It consumes a stream of signed operands over a valid/ready handshake and folds each one into a running sum using the adder's arithmetic (Cin=0, two's-complement overflow, carry-out). After a programmed number of operands it presents the final sum, a sticky overflow flag and the last carry-out. Optional saturation clamps the sum on overflow.

Parameters:
WIDTH, 32, operand/accumulator width in bits (two's complement)
COUNT_W, 8, width of the operand-count field; a job has at most 2^COUNT_W-1 operands

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  start a job; sampled only in IDLE
len  input  COUNT_W  number of operands in the job; sampled with start
sat_en  input  1  saturation enable; sampled with start, held for the whole job
in_valid  input  1  operand valid
in_data  input  WIDTH  signed operand
in_ready  output  1  high only in ACCUM
out_valid  output  1  result valid; high only in DONE
out_ready  input  1  result consumed when out_valid && out_ready
result  output  WIDTH  signed accumulated sum
overflow  output  1  sticky: set if any add in the job overflowed
cout_last  output  1  unsigned carry-out of the most recent add
busy  output  1  high in ACCUM or DONE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=0, remaining=0, overflow=0, cout_last=0, sat latch=0. Outputs in_ready=0, out_valid=0, busy=0, result=0.
- FSM states: IDLE, ACCUM, DONE.
- IDLE, start=1, len!=0: clear acc, overflow and cout_last; load remaining=len; latch sat_en; go to ACCUM next cycle.
- IDLE, start=1, len==0: clear acc, overflow and cout_last; go straight to DONE with result=0.
- IDLE, start=0: hold all state.
- ACCUM: in_ready=1. A beat is accepted when in_valid=1.
  - Per accepted beat: s = acc + in_data, computed WIDTH+1 wide with Cin=0. cout_last = bit WIDTH of s.
  - ovf = (acc[MSB]==in_data[MSB]) && (s[MSB]!=acc[MSB]).
  - If ovf && sat_en latched: acc = acc[MSB] ? most-negative : most-positive. Otherwise acc = s[WIDTH-1:0], wrapping.
  - overflow |= ovf. remaining decrements by 1.
  - When the beat with remaining==1 is accepted, go to DONE next cycle.
  - No accepted beat: hold all state.
- Latency: result, overflow and cout_last reflect the last operand one cycle after its acceptance, at the same edge out_valid rises.
- DONE: out_valid=1. result, overflow and cout_last are held stable until out_valid && out_ready, then go to IDLE next cycle. Values are retained in IDLE until the next start.
- start and len are ignored outside IDLE. in_valid is ignored outside ACCUM; no beat is accepted.
- Saturation does not clear overflow; the sticky flag still reports the event.
- Once saturated, a later add is computed from the clamped value.
- Reset asserted mid-job aborts it immediately: all state cleared, no out_valid pulse. After rst_n deasserts, the block waits in IDLE for a new start.
- result is a registered output; no combinational path from in_data to result.

Test Plan:
1. start, len=2, sat_en=0; operands 0x00000001, 0x00000001 -> out_valid one cycle after 2nd accept; result=0x00000002, overflow=0, cout_last=0.
2. len=2, sat_en=0; operands 0x40000000, 0x40000000 -> result=0x80000000, overflow=1, cout_last=0. Repeat with sat_en=1 -> result=0x7FFFFFFF, overflow=1.
3. len=3, sat_en=1; operands 0x80000000, 0xFFFFFFFF, 0x00000001 -> after beat 2 acc=0x80000000 (clamped), overflow=1, cout_last=1. Final result=0x80000001, overflow=1 (sticky), cout_last=0.
4. len=2, sat_en=0; operands 0xFFFFFFFF, 0xFFFFFFFF -> result=0xFFFFFFFE, overflow=0, cout_last=1. Then len=0 job -> out_valid next cycle, result=0, overflow=0, cout_last=0.
5. Handshake: in_valid gaps of 2 cycles between beats -> no extra accepts, correct sum. out_ready held low 3 cycles in DONE -> result stable, out_valid stays 1; start pulsed during DONE is ignored. Returns to IDLE one cycle after out_ready=1.
6. len=4; drop rst_n asynchronously (between edges) after 2 accepts -> outputs zero immediately, state IDLE, no out_valid. New job len=1, operand 0x00000005 -> result=0x00000005.
